// File: rtl/neuron_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the neuron accumulation controller.
// Holds default widths, signed saturation limits, FSM state encodings
// and the signed-overflow helper used when capturing adder sums.
package neuron_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int TERM_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    // Saturation limits for the default 16b accumulator.
    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = 16'sh7FFF;
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = 16'sh8000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_ISSUE   = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_CAPTURE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Signed add overflows when both operands share a sign and the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/neuron_accum_ctrl.sv
`timescale 1ns/1ps
// Purpose : sequences an external registered signed adder to accumulate bias + N terms,
//           with optional saturation, and presents the 16b pre-activation result.
// Latency : start -> o_out_valid = 2 + N*(ADD_LAT+2) cycles; one term per ADD_LAT+2 cycles.
// Backpr. : o_term_ready only in ISSUE; result held in DONE until i_out_ready; start ignored while busy.
// Ports   : i_clk/i_rst (sync, active high); i_start/i_bias/i_num_terms op request;
//           i_term_valid/i_term_data/o_term_ready term stream; o_add_in1/o_add_in2/i_add_sum/
//           i_add_carry adder interface; o_busy, o_out_valid/o_out_data/i_out_ready result,
//           o_sat_flag overflow indicator valid with o_out_valid.
module neuron_accum_ctrl
    import neuron_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int TERM_W   = TERM_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ADD_LAT  = 1,
    parameter bit SATURATE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ACC_W-1:0]  i_bias,
    input  logic [CNT_W-1:0]  i_num_terms,
    input  logic              i_term_valid,
    input  logic [TERM_W-1:0] i_term_data,
    output logic              o_term_ready,
    output logic [ACC_W-1:0]  o_add_in1,
    output logic [TERM_W-1:0] o_add_in2,
    input  logic [ACC_W-1:0]  i_add_sum,
    input  logic              i_add_carry,
    output logic              o_busy,
    output logic              o_out_valid,
    output logic [ACC_W-1:0]  o_out_data,
    input  logic              i_out_ready,
    output logic              o_sat_flag
);

    localparam int WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_remain;
    logic [WAIT_W-1:0]   r_wait;
    logic [ACC_W-1:0]    r_add_in1;
    logic [TERM_W-1:0]   r_add_in2;
    logic                r_busy;
    logic                r_out_valid;
    logic [ACC_W-1:0]    r_out_data;
    logic                r_sat_flag;

    logic                w_handshake;
    logic                w_ovf;
    logic [ACC_W-1:0]    w_capture;
    logic                w_unused;

    // Carry is only observed for debug; overflow comes from sign bits.
    assign w_unused = i_add_carry;

    assign o_term_ready = (r_state == ST_ISSUE);
    assign w_handshake  = i_term_valid && o_term_ready;

    // Operands are held in r_add_in1/2 through WAIT, so they still describe the sum in CAPTURE.
    assign w_ovf = add_ovf(r_add_in1[ACC_W-1], r_add_in2[TERM_W-1], i_add_sum[ACC_W-1]);

    always_comb begin
        w_capture = i_add_sum;
        if (w_ovf && SATURATE) begin
            w_capture = r_add_in1[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_remain    <= '0;
            r_wait      <= '0;
            r_add_in1   <= '0;
            r_add_in2   <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_flag  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_acc    <= i_bias;
                        r_remain <= i_num_terms;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= (r_remain == '0) ? ST_DONE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_handshake) begin
                        r_add_in1 <= r_acc;
                        r_add_in2 <= i_term_data;
                        r_wait    <= WAIT_W'(ADD_LAT - 1);
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    // A saturated value becomes the next operand; no later wrap recovery.
                    r_acc      <= w_capture;
                    r_sat_flag <= r_sat_flag | w_ovf;
                    r_remain   <= r_remain - CNT_W'(1);
                    r_state    <= (r_remain == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
                end
                ST_DONE: begin
                    // out_valid rises one cycle after entering DONE; start is not looked at here.
                    if (r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_sat_flag  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_add_in1   = r_add_in1;
    assign o_add_in2   = r_add_in2;
    assign o_busy      = r_busy;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
`timescale 1ns/1ps
// Bench for neuron_accum_ctrl: one saturating and one wrapping instance share stimulus,
// each driving its own registered 1-cycle adder model.
module tb_neuron_accum_ctrl;
    import neuron_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, term_valid, out_ready;
    logic [15:0] bias;
    logic [7:0]  num_terms, term_data;

    logic        s_term_ready, s_busy, s_out_valid, s_sat_flag, s_add_carry;
    logic [15:0] s_add_in1, s_add_sum, s_out_data;
    logic [7:0]  s_add_in2;
    logic        w_term_ready, w_busy, w_out_valid, w_sat_flag, w_add_carry;
    logic [15:0] w_add_in1, w_add_sum, w_out_data;
    logic [7:0]  w_add_in2;

    neuron_accum_ctrl #(.SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bias(bias), .i_num_terms(num_terms),
        .i_term_valid(term_valid), .i_term_data(term_data), .o_term_ready(s_term_ready),
        .o_add_in1(s_add_in1), .o_add_in2(s_add_in2), .i_add_sum(s_add_sum),
        .i_add_carry(s_add_carry), .o_busy(s_busy), .o_out_valid(s_out_valid),
        .o_out_data(s_out_data), .i_out_ready(out_ready), .o_sat_flag(s_sat_flag)
    );

    neuron_accum_ctrl #(.SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bias(bias), .i_num_terms(num_terms),
        .i_term_valid(term_valid), .i_term_data(term_data), .o_term_ready(w_term_ready),
        .o_add_in1(w_add_in1), .o_add_in2(w_add_in2), .i_add_sum(w_add_sum),
        .i_add_carry(w_add_carry), .o_busy(w_busy), .o_out_valid(w_out_valid),
        .o_out_data(w_out_data), .i_out_ready(out_ready), .o_sat_flag(w_sat_flag)
    );

    // Registered adders: 16b + sign-extended 8b, one cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            {s_add_carry, s_add_sum} <= '0;
            {w_add_carry, w_add_sum} <= '0;
        end else begin
            {s_add_carry, s_add_sum} <= {1'b0, s_add_in1} + {1'b0, {8{s_add_in2[7]}}, s_add_in2};
            {w_add_carry, w_add_sum} <= {1'b0, w_add_in1} + {1'b0, {8{w_add_in2[7]}}, w_add_in2};
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] x);
        return {{16{x[15]}}, x};
    endfunction

    typedef struct packed {
        logic [15:0]      bias;
        logic [7:0]       n;
        logic [3:0][7:0]  terms;
        logic [3:0][3:0]  gaps;
        logic [15:0]      exp_sat;
        logic [15:0]      exp_wrap;
        logic             exp_flag;
        logic [7:0]       exp_lat;   // 0: latency not checked (idle gaps present)
        logic [15:0]      exp_a1;    // saturating operand A for the second term
    } vec_t;

    function automatic vec_t mk(input int b, input int n, input int t0, input int t1,
                                input int t2, input int g0, input int g1, input int g2,
                                input int es, input int ew, input int ef, input int el,
                                input int ea1);
        vec_t v;
        v = '0;
        v.bias = 16'(b); v.n = 8'(n);
        v.terms[0] = 8'(t0); v.terms[1] = 8'(t1); v.terms[2] = 8'(t2);
        v.gaps[0] = 4'(g0); v.gaps[1] = 4'(g1); v.gaps[2] = 4'(g2);
        v.exp_sat = 16'(es); v.exp_wrap = 16'(ew); v.exp_flag = 1'(ef);
        v.exp_lat = 8'(el); v.exp_a1 = 16'(ea1);
        return v;
    endfunction

    // Runs one op up to out_valid (no result handshake). Outside ISSUE, term_valid is
    // driven high with junk data, which the controller must ignore.
    task automatic run_op(input vec_t v, output int lat, output int tr_cnt,
                          output logic [15:0] a1);
        int idx, gap;
        logic hs_pending;
        @(posedge clk); #1;
        start = 1'b1; bias = v.bias; num_terms = v.n;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; idx = 0; gap = int'(v.gaps[0]); tr_cnt = 0; hs_pending = 1'b0; a1 = '0;
        while (lat < 200) begin
            if (hs_pending) begin
                if (idx == 1) a1 = s_add_in1;
                idx++;
                gap = (idx < 4) ? int'(v.gaps[idx]) : 0;
                hs_pending = 1'b0;
            end
            if (s_out_valid) break;
            if (s_term_ready) begin
                tr_cnt++;
                if (idx < int'(v.n) && gap > 0) begin
                    gap--;
                    term_valid = 1'b0;
                end else if (idx < int'(v.n)) begin
                    term_valid = 1'b1;
                    term_data  = v.terms[idx];
                    hs_pending = 1'b1;
                end else begin
                    term_valid = 1'b0;
                end
            end else begin
                term_valid = 1'b1;
                term_data  = 8'h7F;
            end
            @(posedge clk); #1;
            lat++;
        end
        term_valid = 1'b0;
    endtask

    task automatic finish_op();
        chk("busy_in_done", 32'(s_busy), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_after_hs", 32'(s_out_valid), 32'd0);
        chk("busy_after_hs", 32'(s_busy), 32'd0);
        chk("flag_after_hs", 32'(s_sat_flag), 32'd0);
    endtask

    vec_t vecs[6];
    int lat, trc, exp_tr;
    logic [15:0] a1;

    initial begin
        vecs[0] = mk(100, 1, 27, 0, 0, 0, 0, 0, 127, 127, 0, 5, 0);
        vecs[1] = mk(50, 3, -20, 30, -60, 0, 0, 0, 0, 0, 0, 11, 30);
        vecs[2] = mk(50, 3, -20, 30, -60, 1, 2, 3, 0, 0, 0, 0, 30);
        vecs[3] = mk(int'(ACC_MAX), 1, 1, 0, 0, 0, 0, 0, int'(ACC_MAX), int'(ACC_MIN), 1, 5, 0);
        vecs[4] = mk(int'(ACC_MIN), 2, -1, 5, 0, 0, 0, 0, -32763, -32764, 1, 8, int'(ACC_MIN));
        vecs[5] = mk(-70, 0, 0, 0, 0, 0, 0, 0, -70, -70, 0, 2, 0);

        rst = 1'b1; start = 1'b0; term_valid = 1'b0; out_ready = 1'b0;
        bias = '0; num_terms = '0; term_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_valid", 32'(s_out_valid), 32'd0);
        chk("rst_flag", 32'(s_sat_flag), 32'd0);
        chk("rst_term_ready", 32'(s_term_ready), 32'd0);
        chk("rst_out_data", sx(s_out_data), 32'd0);
        chk("rst_add_in1", sx(s_add_in1), 32'd0);
        chk("rst_add_in2", 32'(s_add_in2), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], lat, trc, a1);
            chk($sformatf("v%0d_valid", i), 32'(s_out_valid), 32'd1);
            chk($sformatf("v%0d_data_sat", i), sx(s_out_data), sx(vecs[i].exp_sat));
            chk($sformatf("v%0d_data_wrap", i), sx(w_out_data), sx(vecs[i].exp_wrap));
            chk($sformatf("v%0d_flag_sat", i), 32'(s_sat_flag), 32'(vecs[i].exp_flag));
            chk($sformatf("v%0d_flag_wrap", i), 32'(w_sat_flag), 32'(vecs[i].exp_flag));
            if (vecs[i].exp_lat != 0)
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            exp_tr = int'(vecs[i].n);
            for (int k = 0; k < int'(vecs[i].n) && k < 4; k++) exp_tr += int'(vecs[i].gaps[k]);
            chk($sformatf("v%0d_term_ready_cycles", i), 32'(trc), 32'(exp_tr));
            if (vecs[i].n >= 2)
                chk($sformatf("v%0d_acc_after_t0", i), sx(a1), sx(vecs[i].exp_a1));
            finish_op();
        end

        // Result held under backpressure, starts ignored, start coincident with handshake.
        run_op(vecs[0], lat, trc, a1);
        for (int c = 0; c < 5; c++) begin
            start = c[0]; bias = 16'd999; num_terms = 8'd1;
            @(posedge clk); #1;
            chk("hold_valid", 32'(s_out_valid), 32'd1);
            chk("hold_data", sx(s_out_data), 32'd127);
        end
        start = 1'b1; out_ready = 1'b1; bias = 16'd5; num_terms = 8'd0;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        chk("hs_start_valid", 32'(s_out_valid), 32'd0);
        chk("hs_start_busy", 32'(s_busy), 32'd0);
        chk("hs_keep_data", sx(s_out_data), 32'd127);
        @(posedge clk); #1;
        chk("hs_start_stays_idle", 32'(s_busy), 32'd0);

        // Reset while the adder pass is in WAIT.
        start = 1'b1; bias = 16'd10; num_terms = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 10 && !s_term_ready; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_term_ready", 32'(s_term_ready), 32'd1);
        term_valid = 1'b1; term_data = 8'd3;
        @(posedge clk); #1;
        term_valid = 1'b0;
        chk("wait_operand_a", sx(s_add_in1), 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_wait_busy", 32'(s_busy), 32'd0);
        chk("rst_wait_valid", 32'(s_out_valid), 32'd0);
        chk("rst_wait_add_in1", sx(s_add_in1), 32'd0);
        chk("rst_wait_out_data", sx(s_out_data), 32'd0);
        run_op(mk(-120, 1, 50, 0, 0, 0, 0, 0, -70, -70, 0, 5, 0), lat, trc, a1);
        chk("post_rst_valid", 32'(s_out_valid), 32'd1);
        chk("post_rst_data", sx(s_out_data), sx(16'hFFBA));
        chk("post_rst_flag", 32'(s_sat_flag), 32'd0);
        chk("post_rst_latency", 32'(lat), 32'd5);
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
